// File: rtl/sdram_burst_arbiter_if.sv
// Avalon-MM burst port bundle: one instance per DSP master and one toward the SDRAM controller.
interface sdram_burst_arbiter_if #(
    parameter int ADDR_W  = 27,
    parameter int DATA_W  = 256,
    parameter int BURST_W = 8
);
    logic [ADDR_W-1:0]   Address;
    logic [DATA_W/8-1:0] ByteEnable;
    logic [BURST_W-1:0]  BurstCount;
    logic [DATA_W-1:0]   WriteData;
    logic                Write;
    logic                Read;
    logic                WaitRequest;
    logic [DATA_W-1:0]   ReadData;
    logic                ReadValid;

    modport master (
        output Address, ByteEnable, BurstCount, WriteData, Write, Read,
        input  WaitRequest, ReadData, ReadValid
    );
    modport slave (
        input  Address, ByteEnable, BurstCount, WriteData, Write, Read,
        output WaitRequest, ReadData, ReadValid
    );
endinterface

// File: rtl/sdram_burst_arbiter.sv
// Two-master whole-burst arbiter for one Avalon-MM SDRAM port, read returns routed by an in-order tag FIFO.
// Define SDRAM_ARB_ROUND_ROBIN_EN for round-robin on contention; default is fixed M0 priority.
module sdram_burst_arbiter #(
    parameter int ADDR_W    = 27,
    parameter int DATA_W    = 256,
    parameter int BURST_W   = 8,
    parameter int MAX_READS = 4
) (
    input  logic                  ipClk,
    input  logic                  ipReset,
    sdram_burst_arbiter_if.slave  ipM0,
    sdram_burst_arbiter_if.slave  ipM1,
    sdram_burst_arbiter_if.master opSDRAM,
    output logic                  opError
);
    localparam int BE_W  = DATA_W / 8;
    localparam int PTR_W = $clog2(MAX_READS);
    localparam logic [BURST_W-1:0] ONE     = BURST_W'(1);
    localparam logic [PTR_W:0]     PTR_ONE = (PTR_W + 1)'(1);

    typedef enum logic [1:0] {IDLE, GRANT_RD, GRANT_WR} state_t;

    state_t             state_q, state_d;
    logic               gnt_q, gnt_d, first_q, first_d, err_q, err_d;
    logic [BURST_W-1:0] wcnt_q, wcnt_d, rcnt_q, rcnt_d;
    logic [PTR_W:0]     wptr_q, rptr_q;
    logic               tag_id_q  [MAX_READS];
    logic [BURST_W-1:0] tag_len_q [MAX_READS];

    // Per-master request vectors, index = master number
    logic [1:0]              m_wr, m_rd, elig, m_wait;
    logic [1:0][ADDR_W-1:0]  m_addr;
    logic [1:0][BE_W-1:0]    m_be;
    logic [1:0][BURST_W-1:0] m_bc;
    logic [1:0][DATA_W-1:0]  m_wd;

    assign m_wr   = {ipM1.Write, ipM0.Write};
    assign m_rd   = {ipM1.Read, ipM0.Read};
    assign m_addr = {ipM1.Address, ipM0.Address};
    assign m_be   = {ipM1.ByteEnable, ipM0.ByteEnable};
    assign m_bc   = {ipM1.BurstCount, ipM0.BurstCount};
    assign m_wd   = {ipM1.WriteData, ipM0.WriteData};

    logic               empty, full, hit, pop, push, head_id, pick, sd_wr, sd_rd;
    logic [PTR_W-1:0]   head;
    logic [BURST_W-1:0] head_len, wr_len;

    assign empty    = (wptr_q == rptr_q);
    assign full     = (wptr_q[PTR_W] != rptr_q[PTR_W]) &&
                      (wptr_q[PTR_W-1:0] == rptr_q[PTR_W-1:0]);
    assign elig     = m_wr | (m_rd & {2{~full}});
    assign head     = rptr_q[PTR_W-1:0];
    assign head_id  = tag_id_q[head];
    assign head_len = (tag_len_q[head] == '0) ? ONE : tag_len_q[head];
    assign wr_len   = (m_bc[gnt_q] == '0) ? ONE : m_bc[gnt_q];

`ifdef SDRAM_ARB_ROUND_ROBIN_EN
    logic last_q, last_d;
    assign pick   = (&elig) ? ~last_q : ~elig[0];
    assign last_d = (state_q == IDLE && |elig) ? pick : last_q;
    always_ff @(posedge ipClk or negedge ipReset) begin
        if (!ipReset) last_q <= 1'b1;
        else          last_q <= last_d;
    end
`else
    assign pick = ~elig[0];
`endif

    // Read return: beats go to the head tag's owner; the head pops on its last beat
    assign hit    = opSDRAM.ReadValid && !empty;
    assign pop    = hit && (rcnt_q == head_len - ONE);
    assign rcnt_d = pop ? '0 : (hit ? rcnt_q + ONE : rcnt_q);
    assign err_d  = err_q | (opSDRAM.ReadValid & empty);

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        first_d = first_q;
        wcnt_d  = wcnt_q;
        push    = 1'b0;
        m_wait  = 2'b11;
        sd_wr   = 1'b0;
        sd_rd   = 1'b0;
        case (state_q)
            IDLE: if (|elig) begin
                gnt_d   = pick;
                first_d = 1'b1;
                state_d = m_wr[pick] ? GRANT_WR : GRANT_RD;
            end
            GRANT_RD: begin
                m_wait[gnt_q] = opSDRAM.WaitRequest;
                sd_rd         = m_rd[gnt_q];
                if (sd_rd && !opSDRAM.WaitRequest) begin
                    push    = 1'b1;
                    state_d = IDLE;
                end
            end
            GRANT_WR: begin
                m_wait[gnt_q] = opSDRAM.WaitRequest;
                sd_wr         = m_wr[gnt_q];
                // wcnt holds beats still owed after the current one
                if (sd_wr && !opSDRAM.WaitRequest) begin
                    if (first_q) begin
                        first_d = 1'b0;
                        wcnt_d  = wr_len - ONE;
                        if (wr_len == ONE) state_d = IDLE;
                    end else begin
                        wcnt_d = wcnt_q - ONE;
                        if (wcnt_q == ONE) state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign opSDRAM.Address    = m_addr[gnt_q];
    assign opSDRAM.ByteEnable = m_be[gnt_q];
    assign opSDRAM.BurstCount = m_bc[gnt_q];
    assign opSDRAM.WriteData  = m_wd[gnt_q];
    assign opSDRAM.Write      = sd_wr;
    assign opSDRAM.Read       = sd_rd;
    assign ipM0.WaitRequest   = m_wait[0];
    assign ipM1.WaitRequest   = m_wait[1];
    assign ipM0.ReadData      = opSDRAM.ReadData;
    assign ipM1.ReadData      = opSDRAM.ReadData;
    assign ipM0.ReadValid     = hit && !head_id;
    assign ipM1.ReadValid     = hit && head_id;
    assign opError            = err_q;

    always_ff @(posedge ipClk or negedge ipReset) begin
        if (!ipReset) begin
            state_q <= IDLE;
            gnt_q   <= 1'b0;
            first_q <= 1'b1;
            wcnt_q  <= '0;
            rcnt_q  <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            first_q <= first_d;
            wcnt_q  <= wcnt_d;
            rcnt_q  <= rcnt_d;
            err_q   <= err_d;
            if (push) wptr_q <= wptr_q + PTR_ONE;
            if (pop)  rptr_q <= rptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge ipClk) begin
        if (push) begin
            tag_id_q[wptr_q[PTR_W-1:0]]  <= gnt_q;
            tag_len_q[wptr_q[PTR_W-1:0]] <= m_bc[gnt_q];
        end
    end
endmodule

// File: tb/tb_sdram_burst_arbiter.sv
// Directed bench for sdram_burst_arbiter: reset, burst writes, read routing, tag-FIFO full, arbitration, error flag.
module tb_sdram_burst_arbiter;
    localparam int AW = 27, DW = 256, BW = 8;

    logic clk = 1'b0, rst_n = 1'b1, err;
    int   nvec = 0, nerr = 0;
    always #5 clk = ~clk;

    sdram_burst_arbiter_if m0_if ();
    sdram_burst_arbiter_if m1_if ();
    sdram_burst_arbiter_if sd_if ();

    sdram_burst_arbiter dut (
        .ipClk(clk), .ipReset(rst_n), .ipM0(m0_if), .ipM1(m1_if), .opSDRAM(sd_if), .opError(err)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input int m, input logic wr, input logic rd, input logic [AW-1:0] a,
                       input logic [BW-1:0] bc, input logic [DW-1:0] d);
        if (m == 0) begin
            m0_if.Write = wr; m0_if.Read = rd; m0_if.Address = a;
            m0_if.BurstCount = bc; m0_if.WriteData = d; m0_if.ByteEnable = '1;
        end else begin
            m1_if.Write = wr; m1_if.Read = rd; m1_if.Address = a;
            m1_if.BurstCount = bc; m1_if.WriteData = d; m1_if.ByteEnable = '1;
        end
    endtask

    task automatic clr();
        drv(0, 0, 0, '0, '0, '0);
        drv(1, 0, 0, '0, '0, '0);
        sd_if.WaitRequest = 0; sd_if.ReadData = '0; sd_if.ReadValid = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        clr();
        cyc(); cyc();
        rst_n = 1;
        cyc();
    endtask

    function automatic logic mwait(input int m);
        return (m == 0) ? m0_if.WaitRequest : m1_if.WaitRequest;
    endfunction

    // Issue one read command from master m; bounded wait for acceptance
    task automatic do_read(input int m, input logic [AW-1:0] a, input logic [BW-1:0] len);
        logic acc = 0;
        logic [AW-1:0] got = '0;
        drv(m, 0, 1, a, len, '0);
        for (int i = 0; i < 10 && !acc; i++) begin
            @(negedge clk);
            if (!mwait(m) && sd_if.Read) begin acc = 1; got = sd_if.Address; end
            cyc();
        end
        drv(m, 0, 0, '0, '0, '0);
        nvec++;
        if ({acc, got} !== {1'b1, a}) begin
            nerr++; $display("FAIL rd_issue m%0d: accepted=%0b addr=%0h, want 1 addr=%0h", m, acc, got, a);
        end
    endtask

    task automatic test_reset();
        rst_n = 0;
        clr();
        #1;
        nvec++;
        if ({m0_if.WaitRequest, m1_if.WaitRequest, m0_if.ReadValid, m1_if.ReadValid,
             sd_if.Write, sd_if.Read, err} !== 7'b1100000) begin
            nerr++; $display("FAIL reset_outs: got %b want 1100000", {m0_if.WaitRequest, m1_if.WaitRequest,
                m0_if.ReadValid, m1_if.ReadValid, sd_if.Write, sd_if.Read, err});
        end
        cyc(); rst_n = 1; cyc();
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        do_read(0, 27'h100, 3);           // stale M0 read, never returned
        drv(0, 1, 0, 27'h180, 8, 256'h11);
        cyc();                            // grant
        for (int b = 0; b < 3; b++) begin
            m0_if.WriteData = 256'(8'h11 + b);
            cyc();
        end
        rst_n = 0;
        #1;
        nvec++;
        if ({sd_if.Write, sd_if.Read, m0_if.WaitRequest, m1_if.WaitRequest, m0_if.ReadValid, err} !== 6'b001100) begin
            nerr++; $display("FAIL reset_mid_burst: got %b want 001100", {sd_if.Write, sd_if.Read,
                m0_if.WaitRequest, m1_if.WaitRequest, m0_if.ReadValid, err});
        end
        clr();
        cyc(); rst_n = 1; cyc();
        do_read(1, 27'h200, 2);
        for (int b = 0; b < 2; b++) begin
            sd_if.ReadValid = 1; sd_if.ReadData = 256'(8'hC0 + b);
            #1;
            nvec++;
            if ({m0_if.ReadValid, m1_if.ReadValid} !== 2'b01) begin
                nerr++; $display("FAIL post_reset_rv beat%0d: got m0=%b m1=%b want m0=0 m1=1", b, m0_if.ReadValid, m1_if.ReadValid);
            end
            cyc();
        end
        sd_if.ReadValid = 0;
        #1;
        nvec++;
        if (err !== 1'b0) begin nerr++; $display("FAIL post_reset_err: got %b want 0", err); end
    endtask

    task automatic test_write_burst();
        int   beat = 0;
        logic m1held = 1, data_ok = 1;
        do_reset();
        drv(0, 1, 0, 27'h600, 4, 256'hA0);
        drv(1, 1, 0, 27'h700, 1, 256'hB0);
        #1;
        nvec++;
        if ({sd_if.Write, m0_if.WaitRequest, m1_if.WaitRequest} !== 3'b011) begin
            nerr++; $display("FAIL wr_idle0: got %b want 011", {sd_if.Write, m0_if.WaitRequest, m1_if.WaitRequest});
        end
        cyc();
        for (int k = 0; k < 5; k++) begin
            sd_if.WaitRequest = (k == 1);
            m0_if.WriteData = 256'(8'hA0 + beat);
            @(negedge clk);
            if (m1_if.WaitRequest !== 1'b1) m1held = 0;
            if (sd_if.Write && !sd_if.WaitRequest) begin
                if (sd_if.WriteData !== 256'(8'hA0 + beat)) data_ok = 0;
                beat++;
            end
            cyc();
        end
        sd_if.WaitRequest = 0;
        nvec++;
        if (beat != 4) begin nerr++; $display("FAIL wr_beats: got %0d want 4", beat); end
        nvec++;
        if ({m1held, data_ok} !== 2'b11) begin
            nerr++; $display("FAIL wr_hold_data: got m1held=%b data_ok=%b want 1 1", m1held, data_ok);
        end
        #1;
        nvec++;
        if ({sd_if.Write, m0_if.WaitRequest, m1_if.WaitRequest} !== 3'b011) begin
            nerr++; $display("FAIL wr_back_idle: got %b want 011", {sd_if.Write, m0_if.WaitRequest, m1_if.WaitRequest});
        end
        drv(0, 0, 0, '0, '0, '0);
        cyc();
        nvec++;
        if ({sd_if.Write, m1_if.WaitRequest, m0_if.WaitRequest, sd_if.Address, sd_if.WriteData[7:0]} !==
            {3'b101, 27'h700, 8'hB0}) begin
            nerr++; $display("FAIL wr_m1_grant: got wr=%b w1=%b w0=%b a=%0h d=%0h want 1 0 1 700 b0",
                sd_if.Write, m1_if.WaitRequest, m0_if.WaitRequest, sd_if.Address, sd_if.WriteData[7:0]);
        end
        cyc();
        clr();
    endtask

    task automatic test_read_routing();
        do_reset();
        do_read(0, 27'h300, 2);
        do_read(1, 27'h340, 3);
        for (int i = 0; i < 5; i++) begin
            sd_if.ReadValid = 1; sd_if.ReadData = 256'(8'hA0 + i);
            #1;
            nvec++;
            if ({m0_if.ReadValid, m1_if.ReadValid} !== {i < 2, i >= 2}) begin
                nerr++; $display("FAIL rd_route beat%0d: got m0=%b m1=%b want m0=%b m1=%b", i,
                    m0_if.ReadValid, m1_if.ReadValid, i < 2, i >= 2);
            end
            nvec++;
            if (m1_if.ReadData !== 256'(8'hA0 + i)) begin
                nerr++; $display("FAIL rd_data beat%0d: got %0h want %0h", i, m1_if.ReadData[7:0], 8'hA0 + i);
            end
            cyc();
        end
        sd_if.ReadValid = 0;
        #1;
        nvec++;
        if (err !== 1'b0) begin nerr++; $display("FAIL rd_route_err: got %b want 0", err); end
    endtask

    task automatic test_tag_full();
        logic stalled = 1;
        int   n0 = 0, n1 = 0, lastown = -1;
        do_reset();
        for (int i = 0; i < 4; i++) do_read(0, 27'(27'h400 + i * 16), 2);
        drv(1, 0, 1, 27'h500, 1, '0);
        for (int k = 0; k < 6; k++) begin
            sd_if.ReadValid = (k >= 3);   // k=3,4: first burst's two beats
            if (k == 5) sd_if.ReadValid = 0;
            @(negedge clk);
            if (m1_if.WaitRequest !== 1'b1) stalled = 0;
            cyc();
        end
        nvec++;
        if (stalled !== 1'b1) begin nerr++; $display("FAIL full_stall: got %b want 1", stalled); end
        #1;
        nvec++;
        if ({m1_if.WaitRequest, sd_if.Read, sd_if.Address} !== {2'b01, 27'h500}) begin
            nerr++; $display("FAIL full_issue: got w=%b rd=%b a=%0h want 0 1 500", m1_if.WaitRequest, sd_if.Read, sd_if.Address);
        end
        cyc();
        drv(1, 0, 0, '0, '0, '0);
        for (int i = 0; i < 7; i++) begin
            sd_if.ReadValid = 1;
            #1;
            if (m0_if.ReadValid) begin n0++; lastown = 0; end
            if (m1_if.ReadValid) begin n1++; lastown = 1; end
            cyc();
        end
        sd_if.ReadValid = 0;
        nvec++;
        if ({n0, n1, lastown} !== {32'd6, 32'd1, 32'd1}) begin
            nerr++; $display("FAIL full_drain: got m0=%0d m1=%0d last=%0d want 6 1 1", n0, n1, lastown);
        end
    endtask

    task automatic test_contention();
        int gl[8];
        int ng = 0, ex;
        do_reset();
        drv(0, 1, 0, 27'h10, 1, 256'h1);
        drv(1, 1, 0, 27'h20, 1, 256'h2);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (sd_if.Write && !sd_if.WaitRequest && ng < 8) begin
                gl[ng] = m0_if.WaitRequest ? 1 : 0;
                ng++;
            end
            cyc();
        end
        clr();
        nvec++;
        if (ng != 4) begin nerr++; $display("FAIL arb_count: got %0d want 4", ng); end
        for (int i = 0; i < 4 && i < ng; i++) begin
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
            ex = i % 2;
`else
            ex = 0;
`endif
            nvec++;
            if (gl[i] != ex) begin nerr++; $display("FAIL arb_grant%0d: got M%0d want M%0d", i, gl[i], ex); end
        end
        cyc(); cyc();
    endtask

    task automatic test_error();
        do_reset();
        sd_if.ReadValid = 1; sd_if.ReadData = 256'h5A;
        #1;
        nvec++;
        if ({m0_if.ReadValid, m1_if.ReadValid, err} !== 3'b000) begin
            nerr++; $display("FAIL err_drop: got %b want 000", {m0_if.ReadValid, m1_if.ReadValid, err});
        end
        cyc();
        sd_if.ReadValid = 0;
        #1;
        nvec++;
        if (err !== 1'b1) begin nerr++; $display("FAIL err_set: got %b want 1", err); end
        cyc(); cyc(); cyc();
        nvec++;
        if (err !== 1'b1) begin nerr++; $display("FAIL err_sticky: got %b want 1", err); end
    endtask

    initial begin
        clr();
        #2;
        test_reset();
        test_reset_mid_burst();
        test_write_burst();
        test_read_routing();
        test_tag_full();
        test_contention();
        test_error();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
